// File: rtl/delay_line_bank.sv
`default_nettype none
// ============================================================================
//  Module   : delay_line_bank
//  Purpose  : Multi-channel EDSAC-style mercury delay line. Each channel
//             decodes carrier-modulated pulses into one bit per slot, stores
//             it in a shared circular RAM and re-emits it as a modulated
//             pulse train DEPTH+1 slots later, optionally recirculating.
//  Revision : 1.0  initial release
// ============================================================================
module delay_line_bank #(
  parameter int CHANNELS     = 1,
  parameter int DEPTH        = 527,
  parameter int SLOT_CYCLES  = 256,
  parameter int PULSE_CYCLES = 120,
  parameter int MOD_DIV      = 10,
  parameter int MIN_EDGES    = 4
) (
  input  logic                       clk_in,
  input  logic                       rst,
  input  logic [CHANNELS-1:0]        in,
  input  logic [CHANNELS-1:0]        recirc,
  output logic [CHANNELS-1:0]        out,
  output logic                       ready,
  output logic                       slot_strobe,
  output logic [$clog2(DEPTH)-1:0]   slot_idx,
  output logic                       led0,
  output logic                       led1
);

  localparam int c_IDX_W     = $clog2(DEPTH);
  localparam int c_SLOT_W    = $clog2(SLOT_CYCLES);
  localparam int c_PHASE_W   = $clog2(MOD_DIV);
  localparam int c_EDGE_W    = $clog2(MIN_EDGES + 1);
  localparam int c_STRETCH_W = 20;

  localparam logic [c_IDX_W-1:0]   c_IDX_LAST   = c_IDX_W'(DEPTH - 1);
  localparam logic [c_SLOT_W-1:0]  c_SLOT_LAST  = c_SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [c_SLOT_W-1:0]  c_PULSE_END  = c_SLOT_W'(PULSE_CYCLES);
  localparam logic [c_PHASE_W-1:0] c_PHASE_LAST = c_PHASE_W'(MOD_DIV - 1);
  localparam logic [c_PHASE_W-1:0] c_PHASE_HALF = c_PHASE_W'(MOD_DIV / 2);
  localparam logic [c_EDGE_W-1:0]  c_EDGE_MIN   = c_EDGE_W'(MIN_EDGES);
  localparam logic [c_EDGE_W-1:0]  c_EDGE_PRE   = c_EDGE_W'(MIN_EDGES - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [c_IDX_W-1:0]     r_slot_idx;
  logic [c_SLOT_W-1:0]    r_slot_cnt;
  logic [c_PHASE_W-1:0]   r_phase;
  logic [CHANNELS-1:0]    r_sync1;
  logic [CHANNELS-1:0]    r_sync2;
  logic [CHANNELS-1:0]    r_sync_d;
  logic [CHANNELS-1:0]    r_tx_bit;
  logic [CHANNELS-1:0]    r_out;
  logic                   r_ready;
  logic                   r_led1;
  logic [c_STRETCH_W-1:0] r_stretch;

  // Storage carries no reset; CLEAR state scrubs it after every reset.
  logic [CHANNELS-1:0]    r_mem [DEPTH];

  logic                   w_run;
  logic                   w_slot_end;
  logic                   w_mem_we;
  logic                   w_carrier;
  logic [CHANNELS-1:0]    w_rise;
  logic [CHANNELS-1:0]    w_new_bit;
  logic [CHANNELS-1:0]    w_rd;
  logic [CHANNELS-1:0]    w_wr_data;

  // State register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) r_state <= ST_CLEAR;
    else     r_state <= w_state_nxt;
  end

  // Next state and per-cycle control: leave CLEAR once the last address is scrubbed.
  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    w_mem_we    = 1'b0;
    w_slot_end  = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_mem_we = 1'b1;
        if (r_slot_idx == c_IDX_LAST) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_run      = 1'b1;
        w_slot_end = (r_slot_cnt == c_SLOT_LAST);
        w_mem_we   = w_slot_end;
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  // Two-flop synchroniser plus a delayed copy for rising-edge detection.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_sync_d <= '0;
    end else begin
      r_sync1  <= in;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_sync_d;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [c_EDGE_W-1:0] r_edge_cnt;

      // Saturating per-slot edge count; emptied at every slot end.
      always_ff @(posedge clk_in or posedge rst) begin
        if (rst)                               r_edge_cnt <= '0;
        else if (!w_run || w_slot_end)         r_edge_cnt <= '0;
        else if (w_rise[gi] && (r_edge_cnt != c_EDGE_MIN))
                                               r_edge_cnt <= r_edge_cnt + 1'b1;
      end

      // An edge landing on the slot-end cycle still counts toward the decision.
      assign w_new_bit[gi] = (r_edge_cnt == c_EDGE_MIN) ||
                             (w_rise[gi] && (r_edge_cnt == c_EDGE_PRE));
    end
  endgenerate

  // Read happens combinationally before the same-edge write: read-before-write.
  assign w_rd      = r_mem[r_slot_idx];
  assign w_wr_data = w_run ? ((recirc & w_rd) | (~recirc & w_new_bit)) : '0;

  // RAM write port: scrub during CLEAR, store one bit per channel at slot end.
  always_ff @(posedge clk_in) begin
    if (w_mem_we) r_mem[r_slot_idx] <= w_wr_data;
  end

  // Circular RAM pointer, shared by the scrub sweep and the slot sequence.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)           r_slot_idx <= '0;
    else if (w_mem_we) r_slot_idx <= (r_slot_idx == c_IDX_LAST) ? '0 : r_slot_idx + 1'b1;
  end

  // Slot timing and carrier phase; phase realigns at every slot start.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_slot_cnt <= '0;
      r_phase    <= '0;
    end else if (!w_run) begin
      r_slot_cnt <= '0;
      r_phase    <= '0;
    end else if (w_slot_end) begin
      r_slot_cnt <= '0;
      r_phase    <= '0;
    end else begin
      r_slot_cnt <= r_slot_cnt + 1'b1;
      r_phase    <= (r_phase == c_PHASE_LAST) ? '0 : r_phase + 1'b1;
    end
  end

  // Bit being transmitted in the coming slot, taken from the RAM read at slot end.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)             r_tx_bit <= '0;
    else if (!w_run)     r_tx_bit <= '0;
    else if (w_slot_end) r_tx_bit <= w_rd;
  end

  assign w_carrier = w_run && (r_slot_cnt < c_PULSE_END) && (r_phase < c_PHASE_HALF);

  // Registered modulated output and ready flag.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_out   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_out   <= r_tx_bit & {CHANNELS{w_carrier}};
      r_ready <= (w_state_nxt == ST_RUN);
    end
  end

  // Activity LED: reload the stretch counter while any output is high, then bleed down.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_stretch <= '0;
      r_led1    <= 1'b0;
    end else begin
      if (|r_out)                r_stretch <= '1;
      else if (r_stretch != '0)  r_stretch <= r_stretch - 1'b1;
      r_led1 <= (|r_out) || (r_stretch != '0);
    end
  end

  assign out         = r_out;
  assign ready       = r_ready;
  assign led0        = r_ready;
  assign led1        = r_led1;
  assign slot_strobe = w_slot_end;
  assign slot_idx    = r_slot_idx;

endmodule
`default_nettype wire

// File: tb/tb_delay_line_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_delay_line_bank
//  Purpose  : Self-checking bench for delay_line_bank with a slot-level
//             queue model of the delay line.
//  Revision : 1.0  initial release
// ============================================================================
module tb_delay_line_bank;

  localparam int CH    = 4;
  localparam int DEPTH = 8;
  localparam int SLOT  = 64;
  localparam int PULSE = 30;
  localparam int MODD  = 6;
  localparam int MINE  = 4;
  localparam int NP    = (PULSE + MODD - 1) / MODD;
  localparam int IDXW  = $clog2(DEPTH);

  logic            clk;
  logic            rst;
  logic [CH-1:0]   in_s;
  logic [CH-1:0]   rc_s;
  logic [CH-1:0]   out_s;
  logic            ready;
  logic            slot_strobe;
  logic [IDXW-1:0] slot_idx;
  logic            led0;
  logic            led1;

  delay_line_bank #(
    .CHANNELS(CH), .DEPTH(DEPTH), .SLOT_CYCLES(SLOT),
    .PULSE_CYCLES(PULSE), .MOD_DIV(MODD), .MIN_EDGES(MINE)
  ) dut (
    .clk_in(clk), .rst(rst), .in(in_s), .recirc(rc_s), .out(out_s),
    .ready(ready), .slot_strobe(slot_strobe), .slot_idx(slot_idx),
    .led0(led0), .led1(led1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  // Per-slot stimulus configuration and observed output pulse counts.
  int            cfg_cnt [CH];
  int            cfg_st  [CH];
  logic [CH-1:0] cfg_rc;
  int            rises   [CH];

  // Reference model: a delay line is a FIFO of DEPTH stored slot bits.
  logic [CH-1:0] mq[$];
  logic [CH-1:0] exp_tx;
  int            exp_idx;
  int            slot_no;

  function automatic void model_reset();
    mq.delete();
    for (int i = 0; i < DEPTH; i++) mq.push_back('0);
    exp_tx  = '0;
    exp_idx = 0;
  endfunction

  function automatic logic lvl(int cnt, int st, int t);
    int d;
    d = t - st;
    return (cnt > 0) && (d >= 0) && (d < cnt * MODD) && ((d % MODD) < MODD / 2);
  endfunction

  function automatic logic [CH-1:0] exp_wave(int t);
    logic on;
    on = (t >= 1) && ((t - 1) < PULSE) && (((t - 1) % MODD) < MODD / 2);
    return on ? exp_tx : '0;
  endfunction

  function automatic void idle_cfg();
    for (int c = 0; c < CH; c++) begin
      cfg_cnt[c] = 0;
      cfg_st[c]  = 0;
    end
    cfg_rc = '0;
  endfunction

  // Run one slot: entered and left #1 after the clock edge that starts a slot.
  task automatic run_slot(input int rst_at);
    logic [CH-1:0] rx, prev, got, popped;
    int bad_t, bad_s;
    logic [CH-1:0] bad_got, bad_exp;
    bad_t = -1; bad_s = -1; prev = '0; bad_got = '0; bad_exp = '0;
    for (int c = 0; c < CH; c++) begin
      rises[c] = 0;
      rx[c]    = (cfg_cnt[c] >= MINE);
    end
    n_chk++;
    if (slot_idx !== IDXW'(exp_idx))
      $display("FAIL slot_idx: slot %0d got %0d expected %0d", slot_no, slot_idx, exp_idx);
    else n_pass++;
    for (int t = 0; t < SLOT; t++) begin
      for (int c = 0; c < CH; c++) in_s[c] = lvl(cfg_cnt[c], cfg_st[c], t);
      rc_s = (t == SLOT - 1) ? cfg_rc : CH'($urandom);
      if (t == rst_at) begin
        n_chk++;
        if (out_s !== exp_wave(t))
          $display("FAIL burst_before_reset: out=%b expected %b", out_s, exp_wave(t));
        else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++;
        if (out_s !== '0) $display("FAIL out_on_reset: out=%b expected 0", out_s);
        else n_pass++;
        return;
      end
      @(negedge clk);
      got = out_s;
      if (got !== exp_wave(t) && bad_t < 0) begin
        bad_t = t; bad_got = got; bad_exp = exp_wave(t);
      end
      if (slot_strobe !== (t == SLOT - 1) && bad_s < 0) bad_s = t;
      for (int c = 0; c < CH; c++) if (got[c] && !prev[c]) rises[c]++;
      prev = got;
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (bad_t >= 0)
      $display("FAIL out_wave: slot %0d cycle %0d out=%b expected %b", slot_no, bad_t, bad_got, bad_exp);
    else n_pass++;
    n_chk++;
    if (bad_s >= 0) $display("FAIL slot_strobe: slot %0d wrong at cycle %0d", slot_no, bad_s);
    else n_pass++;
    popped = mq.pop_front();
    mq.push_back((cfg_rc & popped) | (~cfg_rc & rx));
    exp_tx  = popped;
    exp_idx = (exp_idx + 1) % DEPTH;
    slot_no++;
  endtask

  task automatic do_reset();
    int bad;
    in_s = '0; rc_s = '0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({ready, led0, led1, slot_strobe, out_s, slot_idx} !== '0)
      $display("FAIL reset_state: rdy=%b l0=%b l1=%b strb=%b out=%b idx=%0d expected all 0",
               ready, led0, led1, slot_strobe, out_s, slot_idx);
    else n_pass++;
    rst = 1'b0;
    bad = 0;
    for (int i = 1; i <= DEPTH; i++) begin
      @(posedge clk);
      #1;
      if (i < DEPTH && (ready !== 1'b0 || out_s !== '0 || slot_idx !== IDXW'(i))) bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL clear_phase: %0d bad cycles expected 0", bad);
    else n_pass++;
    n_chk++;
    if (ready !== 1'b1 || led0 !== 1'b1 || slot_idx !== '0)
      $display("FAIL ready_rise: rdy=%b led0=%b idx=%0d expected 1 1 0", ready, led0, slot_idx);
    else n_pass++;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    idle_cfg();
    repeat (DEPTH + 1) run_slot(-1);
  endtask

  task automatic test_single_bit();
    int early, others, got;
    early = 0; others = 0; got = 0;
    idle_cfg();
    cfg_cnt[0] = NP;
    run_slot(-1);
    idle_cfg();
    for (int s = 1; s <= DEPTH + 1; s++) begin
      run_slot(-1);
      if (s <= DEPTH) early += rises[0];
      else got = rises[0];
      for (int c = 1; c < CH; c++) others += rises[c];
    end
    n_chk++;
    if (early != 0) $display("FAIL single_early: %0d pulses expected 0", early);
    else n_pass++;
    n_chk++;
    if (got != NP) $display("FAIL single_pulses: %0d pulses expected %0d", got, NP);
    else n_pass++;
    n_chk++;
    if (others != 0) $display("FAIL single_other_ch: %0d pulses expected 0", others);
    else n_pass++;
    n_chk++;
    if (led1 !== 1'b1) $display("FAIL led1_stretch: led1=%b expected 1", led1);
    else n_pass++;
  endtask

  task automatic test_threshold();
    int obs [DEPTH + 5];
    idle_cfg(); cfg_cnt[0] = MINE - 1;                       run_slot(-1); obs[0] = rises[0];
    idle_cfg(); cfg_cnt[0] = MINE;                           run_slot(-1); obs[1] = rises[0];
    idle_cfg(); cfg_cnt[0] = 3; cfg_st[0] = SLOT - 4 - 2 * MODD; run_slot(-1); obs[2] = rises[0];
    idle_cfg(); cfg_cnt[0] = 3;                              run_slot(-1); obs[3] = rises[0];
    idle_cfg();
    for (int s = 4; s < DEPTH + 5; s++) begin
      run_slot(-1);
      obs[s] = rises[0];
    end
    n_chk++;
    if (obs[DEPTH + 1] != 0) $display("FAIL three_edges: %0d pulses expected 0", obs[DEPTH + 1]);
    else n_pass++;
    n_chk++;
    if (obs[DEPTH + 2] != NP) $display("FAIL four_edges: %0d pulses expected %0d", obs[DEPTH + 2], NP);
    else n_pass++;
    n_chk++;
    if (obs[DEPTH + 3] + obs[DEPTH + 4] != 0)
      $display("FAIL split_edges: %0d pulses expected 0", obs[DEPTH + 3] + obs[DEPTH + 4]);
    else n_pass++;
  endtask

  task automatic test_recirc();
    logic [7:0] pat;
    logic [7:0] seen;
    int obs [96];
    pat = 8'b10110010;
    for (int s = 0; s < 90; s++) begin
      idle_cfg();
      if (s < 8) cfg_cnt[0] = pat[7 - s] ? NP : 0;
      else begin
        cfg_cnt[0] = $urandom_range(0, 8);
        cfg_st[0]  = $urandom_range(0, SLOT - 4 - (cfg_cnt[0] > 0 ? cfg_cnt[0] - 1 : 0) * MODD);
        cfg_rc     = CH'(1);
      end
      run_slot(-1);
      obs[s] = rises[0];
    end
    for (int r = 0; r < 10; r++) begin
      seen = '0;
      for (int k = 0; k < 8; k++) seen[7 - k] = (obs[DEPTH + 1 + 8 * r + k] == NP);
      n_chk++;
      if (seen !== pat) $display("FAIL recirc_rot%0d: pattern %b expected %b", r, seen, pat);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 100; s++) begin
      for (int c = 0; c < CH; c++) begin
        cfg_cnt[c] = $urandom_range(0, 8);
        cfg_st[c]  = $urandom_range(0, SLOT - 4 - (cfg_cnt[c] > 0 ? cfg_cnt[c] - 1 : 0) * MODD);
      end
      cfg_rc = CH'($urandom);
      run_slot(-1);
    end
  endtask

  task automatic test_reset_midop();
    int stale;
    idle_cfg();
    for (int c = 0; c < CH; c++) cfg_cnt[c] = NP;
    run_slot(-1);
    idle_cfg();
    repeat (DEPTH) run_slot(-1);
    run_slot(2);
    do_reset();
    idle_cfg();
    stale = 0;
    for (int s = 0; s <= DEPTH; s++) begin
      run_slot(-1);
      for (int c = 0; c < CH; c++) stale += rises[c];
    end
    n_chk++;
    if (stale != 0) $display("FAIL stale_after_reset: %0d pulses expected 0", stale);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_pass = 0; slot_no = 0;
    rst = 1'b1; in_s = '0; rc_s = '0;
    model_reset();
    idle_cfg();
    test_reset();
    test_single_bit();
    test_threshold();
    test_recirc();
    test_random();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/delay_line_bank.md
# delay_line_bank

Parametrised, multi-channel successor to `delay_line`: each channel detects modulated EDSAC-style pulses and stores one bit per slot in a shared circular RAM. After exactly DEPTH+1 slots, it regenerates the bit as a carrier-modulated pulse. Each channel also has a recirculate mode, which turns the bank into a self-refreshing mercury-tank store. It sits between the pulse front-end and the EDSAC store/arithmetic logic, and `slot_strobe`/`slot_idx` provide the system bit timing.

## Interface
- CHANNELS, 1: number of independent tanks.
- DEPTH, 527: slots of storage per channel, ≥2; total delay (DEPTH+1)·SLOT_CYCLES ≈ 1.001 ms at 135 MHz.
- SLOT_CYCLES, 256: clocks per bit slot; must be > PULSE_CYCLES.
- PULSE_CYCLES, 120: clocks of carrier emitted for a 1 bit.
- MOD_DIV, 10: carrier period in clocks, even, ≥2; 13.5 MHz at 135 MHz.
- MIN_EDGES, 4: rising edges within one slot required to decode a 1; ≥1.

Ports:
- clk_in  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- in  in  CHANNELS  modulated pulse input, asynchronous.
- recirc  in  CHANNELS  1 = channel stores its own read bit and ignores `in`.
- out  out  CHANNELS  modulated pulse output, registered.
- ready  out  1  high once RAM clear completes.
- slot_strobe  out  1  one-cycle pulse on the last clock of each slot.
- slot_idx  out  $clog2(DEPTH)  current RAM pointer.
- led0  out  1  equal to `ready`.
- led1  out  1  high while any `out` bit is high, stretched by 2^20 clocks.

## Operation
- Input conditioning: 2-flop synchroniser per channel, then rising-edge detection on the synchronised signal.
- FSM states: CLEAR and RUN.
- Reset behaviour: reset forces CLEAR. All counters, pointer, tx bits, `out`, `ready`, `slot_strobe`, `led0`, `led1` and the stretch counter go to 0 asynchronously.
- CLEAR: writes 0 to RAM address `slot_idx`, then increments `slot_idx`, once per clock for DEPTH clocks. Slot and edge counters stay at 0. `in` and `recirc` are ignored.
- CLEAR → RUN: after address DEPTH-1 is written, `slot_idx` wraps to 0, the FSM enters RUN, and `ready` rises.
- RUN counters: `slot_cnt` runs 0..SLOT_CYCLES-1 and wraps. `phase` runs 0..MOD_DIV-1 and resets to 0 whenever `slot_cnt` wraps.
- Edge counting: per-channel counter saturates at MIN_EDGES and clears at slot end.
- Slot end (`slot_cnt`=SLOT_CYCLES-1) decode: `new_bit[c]` = (edge count, including an edge in this cycle) ≥ MIN_EDGES.
- Slot end read: `rd[c]` = mem[slot_idx][c], latched into `tx_bit[c]`.
- Slot end write: mem[slot_idx][c] ← `recirc[c]` ? `rd[c]` : `new_bit[c]`.
- Slot end pointer update: `slot_idx` ← `slot_idx`+1, wrapping DEPTH-1 → 0.
- `recirc` is sampled only at slot end. If an edge and `recirc` occur together, recirc wins.
- RAM is read-before-write at the same address, so a bit written at slot-end k is read at slot-end k+DEPTH.
- Output: `out[c]` is registered 1 when `tx_bit[c]` AND `slot_cnt` < PULSE_CYCLES AND `phase` < MOD_DIV/2; otherwise 0.
- Slot alignment: senders align pulse trains to `slot_strobe`. A train straddling a slot boundary is split across slots, and each part is decoded independently.

## Timing
- Delay: a 1 received during slot k is emitted during slot k+DEPTH+1.
  - Output edges lag the ideal slot grid by exactly 1 clock (output register).
  - Input sync adds 2 clocks, which is absorbed within the slot.
- Carrier shape: first `out` rise is 1 clock after `slot_cnt`=0. Each pulse is MOD_DIV/2 clocks high and MOD_DIV/2 low. There are ceil(PULSE_CYCLES/MOD_DIV) pulses, 12 with defaults.
- `slot_strobe`: high during `slot_cnt`=SLOT_CYCLES-1 in RUN only.
- `ready`: rises on clock DEPTH after reset release; the first RUN slot starts on the same clock.
- During CLEAR and for the first DEPTH+1 RUN slots, `out` is 0 unless inputs were received.
- Reset mid-operation: `out` drops immediately; RAM is fully re-cleared before RUN, so no stale bit is ever emitted.
- `recirc` toggled mid-slot has no effect until slot end.

## Test plan
- Reset and clear: release `rst` → `ready`=0 for exactly DEPTH clocks, then 1. `out`=0 throughout CLEAR plus 528 slots with no input.
- Single bit: 12 carrier pulses (5 high/5 low) on in[0] aligned to slot 0 → out[0] shows 12 pulses of 5 clocks starting 528·256+1 clocks after slot 0 start (±2 clocks). Nothing appears in other slots.
- Glitch threshold: 3 edges in a slot → no output. 4 edges → full 12-pulse output. 6 edges split 3/3 across a boundary → no output.
- Recirculate: with DEPTH=8, write 10110010, then hold recirc[0]=1 and drive `in` with junk → same pattern re-emitted every 8 slots for 10 rotations.
- Multi-channel/wrap: CHANNELS=4, DEPTH=8, independent random bits for 100 slots, with recirc toggled randomly at slot boundaries → every `out` slot matches a reference queue model.
- Reset mid-operation: assert `rst` during an output burst → `out`=0 in the same cycle. After re-clear, no stale data appears for DEPTH+1 slots.
